// File: rtl/memory_stage_ws.sv
// memory_stage_ws: memory pipeline stage with req/ack wait-state handshake.
// Drives loads/stores to data memory, builds byte enables and lane-replicated
// store data, extracts and extends load data, stalls upstream while an access
// is outstanding, flags a bus error on timeout and registers the writeback
// bundle.
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// (no request, MisalignW=1). Without it, misaligned addresses are aligned down.
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access outstanding; a new memory op may issue / complete
// WAIT  | request held high, counting cycles until ack or timeout
module memory_stage_ws #(
    parameter int XLEN     = 32,   // datapath width, 32 or 64
    parameter int RD_WIDTH = 5,    // destination register index width
    parameter int TIMEOUT  = 16    // max cycles in WAIT before bus error, 2..255
) (
    input  logic                CLK,
    input  logic                Rst,
    input  logic                ValidM,
    input  logic                RegWriteM,
    input  logic                MemWriteM,
    input  logic                MemReadM,
    input  logic [2:0]          ResultSrcM,
    input  logic [2:0]          DexControlM,
    input  logic [RD_WIDTH-1:0] RD_M,
    input  logic [XLEN-1:0]     ALU_ResultM,
    input  logic [XLEN-1:0]     WriteDataM,
    input  logic [XLEN-1:0]     PCPlus4M,
    input  logic [XLEN-1:0]     Imm_Ext_M,
    input  logic [XLEN-1:0]     PCTargetM,
    output logic                MemReq,
    output logic                MemWe,
    output logic [XLEN-1:0]     MemAddr,
    output logic [XLEN-1:0]     MemWData,
    output logic [XLEN/8-1:0]   MemBE,
    input  logic                MemAck,
    input  logic [XLEN-1:0]     MemRData,
    output logic                StallM,
    output logic                ValidW,
    output logic                RegWriteW,
    output logic [2:0]          ResultSrcW,
    output logic [RD_WIDTH-1:0] RD_W,
    output logic [XLEN-1:0]     ALU_ResultW,
    output logic [XLEN-1:0]     TruncateResultW,
    output logic [XLEN-1:0]     PCPlus4W,
    output logic [XLEN-1:0]     Imm_Ext_W,
    output logic [XLEN-1:0]     PCTargetW,
    output logic                MemErrW,
    output logic                MisalignW
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CNTW = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [CNTW-1:0]   waitCnt;

    logic [1:0]        sizeCode;
    logic [OFFW-1:0]   rawOff;
    logic [OFFW-1:0]   sizeLow;
    logic [OFFW-1:0]   effOff;
    logic              memOp;
    logic              misalign;
    logic              reqOk;
    logic              inWait;
    logic              accessDone;
    logic              timeoutErr;
    logic [NB-1:0]     beBase;
    logic [XLEN-1:0]   laneData;
    logic [XLEN-1:0]   loadExt;
    logic [XLEN-1:0]   truncNext;

    // Access size decode; a doubleword code on a 32-bit datapath degrades to word.
    always_comb begin
        sizeCode = DexControlM[1:0];
        if (XLEN == 32 && sizeCode == 2'b11) begin
            sizeCode = 2'b10;
        end
    end

    // Byte offset, alignment mask for the access size, and misalignment handling.
    always_comb begin
        rawOff = ALU_ResultM[OFFW-1:0];
        case (sizeCode)
            2'b00:   sizeLow = '0;
            2'b01:   sizeLow = OFFW'(1);
            2'b10:   sizeLow = OFFW'(3);
            default: sizeLow = OFFW'(7);
        endcase
        memOp = ValidM & (MemReadM | MemWriteM);
`ifdef MEM_MISALIGN_TRAP_EN
        misalign = memOp & (|(rawOff & sizeLow));
        effOff   = rawOff;
`else
        misalign = 1'b0;
        effOff   = rawOff & ~sizeLow;
`endif
        reqOk = memOp & ~misalign;
    end

    // Handshake control: request, completion, timeout and upstream stall.
    always_comb begin
        inWait     = (state == WAIT);
        accessDone = inWait ? MemAck : (reqOk & MemAck);
        timeoutErr = inWait & ~MemAck & (waitCnt == CNTW'(TIMEOUT));
        MemReq     = ~Rst & (inWait | reqOk);
        StallM     = ~Rst & (inWait | reqOk) & ~accessDone & ~timeoutErr;
        MemWe      = MemWriteM;
        MemAddr    = {ALU_ResultM[XLEN-1:OFFW], effOff};
    end

    // Byte enables: size mask shifted to the lane of the (effective) offset.
    always_comb begin
        case (sizeCode)
            2'b00:   beBase = NB'(1);
            2'b01:   beBase = NB'(3);
            2'b10:   beBase = NB'(15);
            default: beBase = NB'(255);
        endcase
        MemBE = beBase << effOff;
    end

    // Store data: low byte/half/word of WriteDataM replicated across all lanes.
    always_comb begin
        MemWData = '0;
        for (int i = 0; i < NB; i++) begin
            case (sizeCode)
                2'b00:   MemWData[8*i +: 8] = WriteDataM[7:0];
                2'b01:   MemWData[8*i +: 8] = WriteDataM[8*(i%2) +: 8];
                2'b10:   MemWData[8*i +: 8] = WriteDataM[8*(i%4) +: 8];
                default: MemWData[8*i +: 8] = WriteDataM[8*i +: 8];
            endcase
        end
    end

    // Load data: shift the addressed lane down, then sign/zero extend by funct3.
    always_comb begin
        laneData = MemRData >> {effOff, 3'b000};
        case (DexControlM)
            3'b000:  loadExt = XLEN'($signed(laneData[7:0]));
            3'b001:  loadExt = XLEN'($signed(laneData[15:0]));
            3'b010:  loadExt = XLEN'($signed(laneData[31:0]));
            3'b100:  loadExt = XLEN'(laneData[7:0]);
            3'b101:  loadExt = XLEN'(laneData[15:0]);
            3'b110:  loadExt = XLEN'(laneData[31:0]);
            default: loadExt = laneData;
        endcase
        truncNext = (ValidM & MemReadM & accessDone) ? loadExt : '0;
    end

    // FSM: IDLE issues, WAIT counts until ack or timeout; reset aborts an access.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqOk && !MemAck) begin
                        state   <= WAIT;
                        waitCnt <= CNTW'(1);
                    end
                end
                WAIT: begin
                    if (MemAck || waitCnt == CNTW'(TIMEOUT)) begin
                        state   <= IDLE;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + CNTW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    waitCnt <= '0;
                end
            endcase
        end
    end

    // Writeback register: bubble while stalled, otherwise load the completed op.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            ValidW          <= 1'b0;
            RegWriteW       <= 1'b0;
            ResultSrcW      <= '0;
            RD_W            <= '0;
            ALU_ResultW     <= '0;
            TruncateResultW <= '0;
            PCPlus4W        <= '0;
            Imm_Ext_W       <= '0;
            PCTargetW       <= '0;
            MemErrW         <= 1'b0;
            MisalignW       <= 1'b0;
        end else if (StallM) begin
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemErrW   <= 1'b0;
            MisalignW <= 1'b0;
        end else begin
            ValidW          <= ValidM;
            RegWriteW       <= RegWriteM & ~timeoutErr & ~misalign;
            ResultSrcW      <= ResultSrcM;
            RD_W            <= RD_M;
            ALU_ResultW     <= ALU_ResultM;
            TruncateResultW <= truncNext;
            PCPlus4W        <= PCPlus4M;
            Imm_Ext_W       <= Imm_Ext_M;
            PCTargetW       <= PCTargetM;
            MemErrW         <= timeoutErr;
            MisalignW       <= misalign;
        end
    end

endmodule

// File: tb/tb_memory_stage_ws.sv
// Directed bench for memory_stage_ws (XLEN=32, TIMEOUT=16) with a writeback
// scoreboard: expected W bundles are queued when an op is driven and popped
// when the op is due on the W outputs.
module tb_memory_stage_ws;

    logic        CLK = 1'b0;
    logic        Rst;
    logic        ValidM, RegWriteM, MemWriteM, MemReadM;
    logic [2:0]  ResultSrcM, DexControlM;
    logic [4:0]  RD_M;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M, Imm_Ext_M, PCTargetM;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemBE;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        StallM;
    logic        ValidW, RegWriteW;
    logic [2:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] ALU_ResultW, TruncateResultW, PCPlus4W, Imm_Ext_W, PCTargetW;
    logic        MemErrW, MisalignW;

    int passCnt  = 0;
    int totalCnt = 0;

    typedef struct {
        logic        valid;
        logic        regw;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] trunc;
        logic        err;
        logic        mis;
    } expW_t;

    expW_t expQ[$];

    memory_stage_ws #(.XLEN(32), .RD_WIDTH(5), .TIMEOUT(16)) dut (
        .CLK(CLK), .Rst(Rst),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .DexControlM(DexControlM), .RD_M(RD_M),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .Imm_Ext_M(Imm_Ext_M), .PCTargetM(PCTargetM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemBE(MemBE),
        .MemAck(MemAck), .MemRData(MemRData),
        .StallM(StallM),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .ALU_ResultW(ALU_ResultW), .TruncateResultW(TruncateResultW), .PCPlus4W(PCPlus4W),
        .Imm_Ext_W(Imm_Ext_W), .PCTargetW(PCTargetW),
        .MemErrW(MemErrW), .MisalignW(MisalignW)
    );

    // 100 MHz clock
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                         input logic [2:0] dex, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] wd);
        ValidM      = v;
        RegWriteM   = rw;
        MemReadM    = mr;
        MemWriteM   = mw;
        DexControlM = dex;
        RD_M        = rd;
        ResultSrcM  = rd[2:0];
        ALU_ResultM = addr;
        WriteDataM  = wd;
        PCPlus4M    = addr + 32'd4;
        Imm_Ext_M   = addr ^ 32'h0F0F_0F0F;
        PCTargetM   = addr + 32'h100;
    endtask

    task automatic driveIdle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic pushExp(input logic v, input logic rw, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] tr,
                           input logic err, input logic mis);
        expW_t e;
        e.valid = v; e.regw = rw; e.rd = rd; e.alu = alu; e.trunc = tr; e.err = err; e.mis = mis;
        expQ.push_back(e);
    endtask

    task automatic checkW(input string tag);
        expW_t e;
        chk({tag, ".queued"}, 64'(expQ.size() > 0), 64'd1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk({tag, ".ValidW"},    64'(ValidW),          64'(e.valid));
            chk({tag, ".RegWriteW"}, 64'(RegWriteW),       64'(e.regw));
            chk({tag, ".RD_W"},      64'(RD_W),            64'(e.rd));
            chk({tag, ".ResultSrc"}, 64'(ResultSrcW),      64'(e.rd[2:0]));
            chk({tag, ".ALU"},       64'(ALU_ResultW),     64'(e.alu));
            chk({tag, ".PCPlus4"},   64'(PCPlus4W),        64'(e.alu + 32'd4));
            chk({tag, ".Trunc"},     64'(TruncateResultW), 64'(e.trunc));
            chk({tag, ".MemErr"},    64'(MemErrW),         64'(e.err));
            chk({tag, ".Misalign"},  64'(MisalignW),       64'(e.mis));
        end
    endtask

    initial begin
        int stallCnt;
        int bubbles;

        // Reset for 3 cycles with every input active
        Rst      = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        MemAck   = 1'b1;
        MemRData = 32'hFFFF_FFFF;
        tick(); tick(); tick();
        chk("rst.MemReq",    64'(MemReq),          64'd0);
        chk("rst.ValidW",    64'(ValidW),          64'd0);
        chk("rst.RegWriteW", 64'(RegWriteW),       64'd0);
        chk("rst.ALU",       64'(ALU_ResultW),     64'd0);
        chk("rst.Trunc",     64'(TruncateResultW), 64'd0);
        chk("rst.PCTarget",  64'(PCTargetW),       64'd0);
        chk("rst.MemErr",    64'(MemErrW),         64'd0);
        chk("rst.Misalign",  64'(MisalignW),       64'd0);

        // ADD after release: result on W one cycle later
        Rst    = 1'b0;
        MemAck = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd5, 32'h0000_1234, 32'd0);
        pushExp(1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        #1;
        chk("add.MemReq", 64'(MemReq), 64'd0);
        chk("add.StallM", 64'(StallM), 64'd0);
        tick();
        checkW("add");

        // LB at offset 3, zero wait states
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 5'd6, 32'h0000_1003, 32'd0);
        MemAck   = 1'b1;
        MemRData = 32'h80FF_FFFF;
        pushExp(1'b1, 1'b1, 5'd6, 32'h0000_1003, 32'hFFFF_FF80, 1'b0, 1'b0);
        #1;
        chk("lb.MemReq",  64'(MemReq),  64'd1);
        chk("lb.StallM",  64'(StallM),  64'd0);
        chk("lb.MemBE",   64'(MemBE),   64'h8);
        chk("lb.MemAddr", 64'(MemAddr), 64'h1003);
        tick();
        checkW("lb");

        // LBU on the same data
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 5'd7, 32'h0000_1003, 32'd0);
        pushExp(1'b1, 1'b1, 5'd7, 32'h0000_1003, 32'h0000_0080, 1'b0, 1'b0);
        #1;
        chk("lbu.StallM", 64'(StallM), 64'd0);
        tick();
        checkW("lbu");

        // Invalid load with a stray ack: no request, ack ignored
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 5'd8, 32'h0000_1100, 32'd0);
        pushExp(1'b0, 1'b0, 5'd8, 32'h0000_1100, 32'd0, 1'b0, 1'b0);
        #1;
        chk("inv.MemReq", 64'(MemReq), 64'd0);
        chk("inv.StallM", 64'(StallM), 64'd0);
        tick();
        checkW("inv");

        // SB at offset 1: byte replicated to every lane
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 5'd9, 32'h0000_6001, 32'h1234_56A5);
        pushExp(1'b1, 1'b0, 5'd9, 32'h0000_6001, 32'd0, 1'b0, 1'b0);
        #1;
        chk("sb.MemWData", 64'(MemWData), 64'hA5A5_A5A5);
        chk("sb.MemBE",    64'(MemBE),    64'h2);
        chk("sb.MemWe",    64'(MemWe),    64'd1);
        tick();
        checkW("sb");

        // SH at offset 2 with 3 wait states
        MemAck = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 5'd10, 32'h0000_2002, 32'hAAAA_BEEF);
        pushExp(1'b1, 1'b0, 5'd10, 32'h0000_2002, 32'd0, 1'b0, 1'b0);
        #1;
        chk("sh.MemBE",    64'(MemBE),    64'hC);
        chk("sh.MemWData", 64'(MemWData), 64'hBEEF_BEEF);
        stallCnt = 0;
        bubbles  = 0;
        for (int k = 0; k < 3; k++) begin
            if (StallM === 1'b1) stallCnt++;
            tick();
            if (ValidW === 1'b0) bubbles++;
        end
        MemAck = 1'b1;
        #1;
        chk("sh.stall_end", 64'(StallM),   64'd0);
        chk("sh.stall_cnt", 64'(stallCnt), 64'd3);
        chk("sh.bubbles",   64'(bubbles),  64'd3);
        tick();
        MemAck = 1'b0;
        driveIdle();
        checkW("sh");

        // LW with no ack: timeout after 16 stall cycles
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd11, 32'h0000_3000, 32'd0);
        pushExp(1'b1, 1'b0, 5'd11, 32'h0000_3000, 32'd0, 1'b1, 1'b0);
        #1;
        stallCnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (StallM === 1'b1) stallCnt++;
            tick();
        end
        chk("to.stall_cnt", 64'(stallCnt), 64'd16);
        chk("to.stall_end", 64'(StallM),   64'd0);
        tick();
        driveIdle();
        #1;
        chk("to.MemReq_drop", 64'(MemReq), 64'd0);
        checkW("to");

        // Same LW, ack on the cycle the counter reaches TIMEOUT: ack wins
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd12, 32'h0000_3004, 32'd0);
        pushExp(1'b1, 1'b1, 5'd12, 32'h0000_3004, 32'h1234_5678, 1'b0, 1'b0);
        #1;
        stallCnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (StallM === 1'b1) stallCnt++;
            tick();
        end
        chk("toack.stall_cnt", 64'(stallCnt), 64'd16);
        MemAck   = 1'b1;
        MemRData = 32'h1234_5678;
        #1;
        chk("toack.stall_end", 64'(StallM), 64'd0);
        tick();
        MemAck = 1'b0;
        driveIdle();
        checkW("toack");

        // LW at offset 2: trapped or aligned down depending on build
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd13, 32'h0000_4002, 32'd0);
        MemAck   = 1'b1;
        MemRData = 32'hCAFE_F00D;
`ifdef MEM_MISALIGN_TRAP_EN
        pushExp(1'b1, 1'b0, 5'd13, 32'h0000_4002, 32'd0, 1'b0, 1'b1);
        #1;
        chk("mis.MemReq", 64'(MemReq), 64'd0);
        chk("mis.StallM", 64'(StallM), 64'd0);
`else
        pushExp(1'b1, 1'b1, 5'd13, 32'h0000_4002, 32'hCAFE_F00D, 1'b0, 1'b0);
        #1;
        chk("mis.MemAddr", 64'(MemAddr), 64'h4000);
        chk("mis.MemBE",   64'(MemBE),   64'hF);
        chk("mis.MemReq",  64'(MemReq),  64'd1);
        chk("mis.StallM",  64'(StallM),  64'd0);
`endif
        tick();
        MemAck = 1'b0;
        checkW("mis");

        // LH stalled, reset on the 2nd wait cycle aborts the access
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 5'd14, 32'h0000_5000, 32'd0);
        #1;
        chk("rw.StallM", 64'(StallM), 64'd1);
        tick();
        tick();
        Rst = 1'b1;
        #1;
        chk("rw.MemReq_rst", 64'(MemReq), 64'd0);
        tick();
        Rst = 1'b0;
        chk("rw.ValidW", 64'(ValidW), 64'd0);
        driveIdle();
        #1;
        chk("rw.idle_MemReq", 64'(MemReq), 64'd0);
        chk("rw.idle_StallM", 64'(StallM), 64'd0);

        // Following LH completes normally
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 5'd15, 32'h0000_5002, 32'd0);
        MemAck   = 1'b1;
        MemRData = 32'h8001_0000;
        pushExp(1'b1, 1'b1, 5'd15, 32'h0000_5002, 32'hFFFF_8001, 1'b0, 1'b0);
        #1;
        chk("lh.StallM", 64'(StallM), 64'd0);
        chk("lh.MemBE",  64'(MemBE),  64'hC);
        tick();
        MemAck = 1'b0;
        driveIdle();
        checkW("lh");

        chk("scoreboard.empty", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/memory_stage_ws.md
# memory_stage_ws

Parametrised memory pipeline stage with wait-state support, sitting between the execute/memory pipeline register and writeback. It issues loads and stores to a data memory over a req/ack handshake. It generates byte enables and lane-replicated store data, and truncates and sign/zero-extends load data. It stalls upstream until the access completes, raises a timeout bus error, and registers all writeback-bound signals.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- RD_W, 5: destination register index width.
- TIMEOUT, 16: maximum cycles in WAIT before bus error; range 2..255.
- CLK  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- ValidM  in  1  M-stage instruction valid.
- RegWriteM, MemWriteM, MemReadM  in  1 each  control.
- ResultSrcM  in  3  writeback mux select, passed through.
- DexControlM  in  3  funct3 size/extend code: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only).
- RD_M  in  RD_W  destination register.
- ALU_ResultM, WriteDataM, PCPlus4M, Imm_Ext_M, PCTargetM  in  XLEN each  datapath.
- MemReq, MemWe  out  1  request and write strobe.
- MemAddr  out  XLEN  address; MemWData  out  XLEN; MemBE  out  XLEN/8.
- MemAck  in  1  access complete; MemRData  in  XLEN  valid with MemAck.
- StallM  out  1  hold M inputs and upstream stages.
- ValidW, RegWriteW  out  1; ResultSrcW  out  3; RD_W  out  RD_W.
- ALU_ResultW, TruncateResultW, PCPlus4W, Imm_Ext_W, PCTargetW  out  XLEN.
- MemErrW, MisalignW  out  1  bus-error and misalignment flags.

## Operation
- FSM states: IDLE and WAIT. Memory op = ValidM & (MemReadM | MemWriteM).
- IDLE, memory op, not misaligned: MemReq=1 combinationally.
  - MemAck=1 in the same cycle: the access completes with zero wait states and the state stays IDLE.
  - Otherwise go to WAIT with wait counter = 1.
- WAIT: MemReq held at 1 and the counter increments each cycle.
  - MemAck: complete, go to IDLE.
  - Counter == TIMEOUT with no ack: complete with error, go to IDLE, MemReq drops.
- StallM = memory op in progress & not completing this cycle.
- MemAddr = ALU_ResultM. MemWe = MemWriteM.
- MemWData = WriteDataM low byte/half/word replicated across all lanes.
- MemBE = size mask (1, 3, 0xF, 0xFF) shifted left by the byte offset.
- Loads: extract the lane at ALU_ResultM offset from MemRData on the completing cycle. Sign-extend for B/H/W; zero-extend for BU/HU/WU; D is passed as-is.
- Non-memory or invalid instruction: completes in 1 cycle, TruncateResultW=0.
- W register load on completion:
  - ValidW=ValidM; remaining fields pass through.
  - On error, RegWriteW=0 and MemErrW=1.
  - While StallM=1, W receives a bubble: ValidW=0, RegWriteW=0, other fields hold.
- ValidM=0 with MemReadM/MemWriteM=1: no request issued.

## Timing
- Reset: every W output is 0, MemErrW=0, MisalignW=0, state IDLE, counter 0.
- MemReq is forced to 0 in any cycle where Rst=1.
- Reset in WAIT aborts the access. The memory must tolerate a dropped request.
- Latency: non-memory op 1 cycle; memory op 1+N cycles for N wait states; timeout TIMEOUT+1 cycles.
- Upstream holds all M inputs stable while StallM=1.
- MemAck outside a request is ignored.
- MemAck on the same cycle the counter reaches TIMEOUT: the ack wins and MemErrW=0.
- MemErrW and MisalignW are valid for one cycle, aligned with ValidW.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: misaligned accesses (H with addr[0]; W with addr[1:0]; D with addr[2:0]) issue no MemReq. They complete in 1 cycle with MisalignW=1 and RegWriteW=0.
- Not defined: the address is aligned down (offset bits below size forced to 0 for MemAddr, MemBE and extraction), the access proceeds normally, and MisalignW is tied to 0.

## Test plan
- Reset 3 cycles with all inputs active -> all W outputs 0, MemReq=0; after release an ADD result 0x1234 appears on ALU_ResultW 1 cycle later.
- XLEN=32 LB at addr 0x...03, MemAck same cycle, MemRData=0x80FF_FFFF -> TruncateResultW=0xFFFF_FF80, StallM never 1. LBU on the same data -> 0x0000_0080.
- SH at offset 2, WriteDataM=0xAAAA_BEEF, 3 wait states -> MemBE=0xC, MemWData=0xBEEF_BEEF; StallM high 3 cycles; ValidW=1 on cycle 4 after 3 bubbles.
- No ack, TIMEOUT=16 -> StallM high 16 cycles, then MemErrW=1, RegWriteW=0, MemReq drops. A repeat with MemAck on cycle 16 gives MemErrW=0.
- LW at 0x...02 -> with MEM_MISALIGN_TRAP_EN: no MemReq, MisalignW=1, 1-cycle completion. Without it: MemAddr low bits 00, MemBE=0xF, MisalignW=0.
- Rst asserted on the 2nd wait cycle -> MemReq=0 that cycle, state IDLE. A subsequent load completes normally.
